// File: rtl/fetch_queue_if.sv
// Prefetch queue bus: instruction-memory req/ack handshake plus the fetch-stage head view.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
) ();
    logic                   imem_req;
    logic [31:0]            imem_addr;
    logic                   imem_ack;
    logic [31:0]            imem_rdata;
    logic                   stall;
    logic                   redirect;
    logic [31:0]            redirect_pc;
    logic                   inst_valid;
    logic [31:0]            inst;
    logic [31:0]            inst_pc;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, count,
        input  imem_ack, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, count,
        output imem_ack, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential word fetches into a DEPTH-entry {pc, inst} ring,
// head presented to IF/ID; taken-branch redirect flushes and restarts fetching.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic           clk,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int unsigned      PTR_W = $clog2(DEPTH);
    localparam int unsigned      CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e           state_q;
    logic [31:0]      fetch_pc_q;
    logic [31:0]      drop_addr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];

    logic        inst_valid;
    logic        deq;
    logic        enq;
    logic [31:0] target;
    logic        unused_pc_bits;

    assign target         = {bus.redirect_pc[31:2], 2'b00};
    assign unused_pc_bits = ^bus.redirect_pc[1:0];
    assign inst_valid     = (count_q != '0);
    assign deq            = inst_valid & ~bus.stall & ~bus.redirect;
    assign enq            = (state_q == StReq) & bus.imem_ack & ~bus.redirect;
    assign count_next     = count_q + CNT_W'(enq) - CNT_W'(deq);

    // At most one request outstanding; issue only while space remains so an ack always fits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.redirect) begin
                        fetch_pc_q <= target;
                    end else if ((count_q < FULL) || deq) begin
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (bus.redirect) begin
                        fetch_pc_q <= target;
                        if (bus.imem_ack) begin
                            state_q <= StIdle;
                        end else begin
                            state_q     <= StDrop;
                            drop_addr_q <= fetch_pc_q;
                        end
                    end else if (bus.imem_ack) begin
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        if (count_next >= FULL) begin
                            state_q <= StIdle;
                        end
                    end
                end
                StDrop: begin
                    // Abandoned request stays on the bus until the memory answers it.
                    if (bus.redirect) begin
                        fetch_pc_q <= target;
                    end
                    if (bus.imem_ack) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            inst_mem_q[wr_ptr_q] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req   = (state_q != StIdle);
    assign bus.imem_addr  = (state_q == StDrop) ? drop_addr_q : fetch_pc_q;
    assign bus.inst_valid = inst_valid;
    assign bus.inst       = inst_valid ? inst_mem_q[rd_ptr_q] : 32'd0;
    assign bus.inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q] : 32'd0;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory model feeds a scoreboard of expected {pc, inst}; a monitor
// pops and compares on every dequeue while directed sequences check timing points.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          tests     = 0;
    int          fails     = 0;
    int          lat       = 0;
    int          wait_cnt  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic [31:0] exp_fetch = 32'h0;
    bit          in_drop   = 1'b0;
    bit          got;
    logic [31:0] a1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model, output monitor and scoreboard feeder, all evaluated mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.imem_req) begin
                if (wait_cnt >= lat) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = (bus.imem_addr >> 2) + 32'd100;
                    wait_cnt       = 0;
                end else begin
                    bus.imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.imem_ack = 1'b0;
                wait_cnt     = 0;
            end

            if (bus.inst_valid) begin
                if (!bus.stall && !bus.redirect) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: got pc 0x%0h, expected none",
                                 bus.inst_pc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("out_pc", bus.inst_pc, mon_e[63:32]);
                        check("out_inst", bus.inst, mon_e[31:0]);
                    end
                end
            end else begin
                check("idle_inst_zero", bus.inst, 32'd0);
                check("idle_pc_zero", bus.inst_pc, 32'd0);
            end

            if (bus.imem_req && bus.imem_ack) begin
                if (in_drop) begin
                    in_drop = 1'b0;
                end else if (!bus.redirect) begin
                    check("fetch_addr", bus.imem_addr, exp_fetch);
                    exp_q.push_back({exp_fetch, 32'((exp_fetch >> 2) + 32'd100)});
                    exp_fetch += 32'd4;
                end
            end else if (bus.imem_req && bus.redirect) begin
                in_drop = 1'b1;
            end
            if (bus.redirect) begin
                exp_fetch = {bus.redirect_pc[31:2], 2'b00};
                exp_q.delete();
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        #1 reset = 1'b0;
        #2;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_pc", bus.inst_pc, 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_addr", bus.imem_addr, 32'd0);
        repeat (2) tick();
        reset = 1'b1;

        // Zero-wait streaming
        tick();
        check("first_req", 32'(bus.imem_req), 32'd1);
        check("first_addr", bus.imem_addr, 32'h0);
        check("first_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        check("s0_pc", bus.inst_pc, 32'h0);
        check("s0_inst", bus.inst, 32'd100);
        check("s0_addr", bus.imem_addr, 32'h4);
        check("s0_count", 32'(bus.count), 32'd1);
        tick();
        check("s1_pc", bus.inst_pc, 32'h4);
        check("s1_inst", bus.inst, 32'd101);
        check("s1_addr", bus.imem_addr, 32'h8);
        tick();
        check("s2_pc", bus.inst_pc, 32'h8);
        check("s2_inst", bus.inst, 32'd102);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stream_count_le1", 32'(bus.count <= 1), 32'd1);
        end

        // Stall until full, then release
        bus.stall = 1'b1;
        repeat (10) tick();
        check("stall_count", 32'(bus.count), 32'd4);
        check("stall_req", 32'(bus.imem_req), 32'd0);
        check("stall_pc", bus.inst_pc, 32'h1c);
        check("stall_inst", bus.inst, 32'd107);
        bus.stall = 1'b0;
        tick();
        check("resume_req", 32'(bus.imem_req), 32'd1);
        check("resume_addr", bus.imem_addr, 32'h2c);
        check("resume_pc", bus.inst_pc, 32'h20);
        check("resume_inst", bus.inst, 32'd108);
        check("resume_count", 32'(bus.count), 32'd3);

        // Three-cycle memory latency
        lat = 2;
        repeat (15) tick();
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (bus.imem_ack) got = 1'b1;
        end
        check("lat_ack_seen", 32'(got), 32'd1);
        a1 = bus.imem_addr;
        tick();
        check("lat_req_c1", 32'(bus.imem_req), 32'd1);
        check("lat_addr_c1", bus.imem_addr, a1);
        tick();
        check("lat_req_c2", 32'(bus.imem_req), 32'd1);
        check("lat_addr_c2", bus.imem_addr, a1);
        tick();
        check("lat_next_addr", bus.imem_addr, a1 + 32'd4);

        // Redirect with queue occupied and nothing in flight
        lat = 0;
        bus.stall = 1'b1;
        repeat (10) tick();
        check("pre_redir_count", 32'(bus.count), 32'd4);
        check("pre_redir_req", 32'(bus.imem_req), 32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        bus.stall       = 1'b0;
        tick();
        bus.redirect = 1'b0;
        check("redir_valid", 32'(bus.inst_valid), 32'd0);
        check("redir_count", 32'(bus.count), 32'd0);
        check("redir_req", 32'(bus.imem_req), 32'd0);
        tick();
        check("redir_new_req", 32'(bus.imem_req), 32'd1);
        check("redir_new_addr", bus.imem_addr, 32'h40);
        tick();
        check("redir_out_valid", 32'(bus.inst_valid), 32'd1);
        check("redir_out_pc", bus.inst_pc, 32'h40);
        check("redir_out_inst", bus.inst, 32'd116);

        // Redirect during an outstanding fetch of 0x10
        bus.stall = 1'b1;
        repeat (10) tick();
        lat             = 2;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h10;
        bus.stall       = 1'b0;
        tick();
        bus.redirect = 1'b0;
        tick();
        check("drop_req0", 32'(bus.imem_req), 32'd1);
        check("drop_addr0", bus.imem_addr, 32'h10);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h83;
        tick();
        bus.redirect = 1'b0;
        check("drop_req1", 32'(bus.imem_req), 32'd1);
        check("drop_addr1", bus.imem_addr, 32'h10);
        check("drop_valid1", 32'(bus.inst_valid), 32'd0);
        tick();
        check("drop_req2", 32'(bus.imem_req), 32'd1);
        check("drop_addr2", bus.imem_addr, 32'h10);
        tick();
        check("drop_done_req", 32'(bus.imem_req), 32'd0);
        check("drop_done_addr", bus.imem_addr, 32'h80);
        tick();
        check("drop_new_req", 32'(bus.imem_req), 32'd1);
        check("drop_new_addr", bus.imem_addr, 32'h80);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (bus.inst_valid) got = 1'b1;
        end
        check("drop_out_seen", 32'(got), 32'd1);
        check("drop_out_pc", bus.inst_pc, 32'h80);
        check("drop_out_inst", bus.inst, 32'd132);

        // Reset in the middle of a request with two entries held
        bus.stall = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.count == 2) got = 1'b1;
            else tick();
        end
        check("mid_count2", 32'(got), 32'd1);
        check("mid_req", 32'(bus.imem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        exp_fetch = 32'h0;
        in_drop   = 1'b0;
        check("mid_rst_req", 32'(bus.imem_req), 32'd0);
        check("mid_rst_valid", 32'(bus.inst_valid), 32'd0);
        check("mid_rst_inst", bus.inst, 32'd0);
        check("mid_rst_pc", bus.inst_pc, 32'd0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        tick();
        bus.stall = 1'b0;
        lat       = 0;
        reset     = 1'b1;
        tick();
        check("restart_req", 32'(bus.imem_req), 32'd1);
        check("restart_addr", bus.imem_addr, 32'h0);
        tick();
        check("restart_pc", bus.inst_pc, 32'h0);
        check("restart_inst", bus.inst, 32'd100);
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
